decode_stage_registered: RTL and testbench

Next-generation MIPS instruction-decode stage.
- Includes the register file, a 3-source forwarding unit and a load-use hazard detector.
- Registers its outputs into an integrated ID/EX pipeline register with valid, stall and flush control.
- Generalised in register-file depth, data width and immediate width; adds zero-extend mode, branch-target computation and a stall counter.
- Sits between the IF/ID register and the execute stage.

---
 rtl/decode_stage_registered_if.sv | 67 ++++++
 rtl/decode_stage_registered.sv | 162 ++++++++++++++++
 tb/tb_decode_stage_registered.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/decode_stage_registered_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// decode_stage_registered_if : IF/ID, bypass and ID/EX signals of the decode stage
// Revision: 1.0
// ----------------------------------------------------------------------------
interface decode_stage_registered_if #(
  parameter int NB_DATA         = 32,
  parameter int NB_REG_ADDRESS  = 5,
  parameter int NB_OP_FIELD     = 6,
  parameter int NB_JUMP_ADDRESS = 26,
  parameter int NB_STALL_CNT    = 16
) ();
  logic                       i_instr_valid;
  logic [NB_DATA-1:0]         i_instruccion;
  logic [NB_DATA-1:0]         i_pc_plus4;
  logic                       i_flush;
  logic                       i_stall_ext;
  logic                       i_zero_extend;
  logic                       i_reg_write_ex;
  logic                       i_mem_read_ex;
  logic [NB_REG_ADDRESS-1:0]  i_rd_ex;
  logic [NB_DATA-1:0]         i_dato_ex;
  logic                       i_reg_write_mem;
  logic [NB_REG_ADDRESS-1:0]  i_rd_mem;
  logic [NB_DATA-1:0]         i_dato_mem;
  logic                       i_reg_write_wb;
  logic [NB_REG_ADDRESS-1:0]  i_rd_wb;
  logic [NB_DATA-1:0]         i_dato_wb;
  logic [NB_REG_ADDRESS-1:0]  i_direc_debug;

  logic                       o_stall;
  logic                       o_valid;
  logic [NB_DATA-1:0]         o_dato_ra;
  logic [NB_DATA-1:0]         o_dato_rb;
  logic [NB_DATA-1:0]         o_inmediato;
  logic [NB_DATA-1:0]         o_branch_target;
  logic [NB_REG_ADDRESS-1:0]  o_direccion_rs;
  logic [NB_REG_ADDRESS-1:0]  o_direccion_rt;
  logic [NB_REG_ADDRESS-1:0]  o_direccion_rd;
  logic [NB_OP_FIELD-1:0]     o_campo_op;
  logic [5:0]                 o_funct;
  logic [NB_JUMP_ADDRESS-1:0] o_dato_direc_jump;
  logic [NB_DATA-1:0]         o_pc_plus4;
  logic [NB_DATA-1:0]         o_dato_debug;
  logic [NB_STALL_CNT-1:0]    o_stall_count;

  modport master (
    output i_instr_valid, i_instruccion, i_pc_plus4, i_flush, i_stall_ext, i_zero_extend,
           i_reg_write_ex, i_mem_read_ex, i_rd_ex, i_dato_ex,
           i_reg_write_mem, i_rd_mem, i_dato_mem,
           i_reg_write_wb, i_rd_wb, i_dato_wb, i_direc_debug,
    input  o_stall, o_valid, o_dato_ra, o_dato_rb, o_inmediato, o_branch_target,
           o_direccion_rs, o_direccion_rt, o_direccion_rd, o_campo_op, o_funct,
           o_dato_direc_jump, o_pc_plus4, o_dato_debug, o_stall_count
  );

  modport slave (
    input  i_instr_valid, i_instruccion, i_pc_plus4, i_flush, i_stall_ext, i_zero_extend,
           i_reg_write_ex, i_mem_read_ex, i_rd_ex, i_dato_ex,
           i_reg_write_mem, i_rd_mem, i_dato_mem,
           i_reg_write_wb, i_rd_wb, i_dato_wb, i_direc_debug,
    output o_stall, o_valid, o_dato_ra, o_dato_rb, o_inmediato, o_branch_target,
           o_direccion_rs, o_direccion_rt, o_direccion_rd, o_campo_op, o_funct,
           o_dato_direc_jump, o_pc_plus4, o_dato_debug, o_stall_count
  );
endinterface
`default_nettype wire

// File: rtl/decode_stage_registered.sv
`default_nettype none
// ----------------------------------------------------------------------------
// decode_stage_registered : MIPS decode with register file, forwarding, load-use
// hazard detection and an integrated ID/EX register.  Revision: 1.0
// ----------------------------------------------------------------------------
module decode_stage_registered #(
  parameter int NB_DATA         = 32,
  parameter int NB_REG_ADDRESS  = 5,
  parameter int NB_IMM          = 16,
  parameter int NB_OP_FIELD     = 6,
  parameter int NB_JUMP_ADDRESS = 26,
  parameter int NB_STALL_CNT    = 16
) (
  input  wire logic                   i_clock,
  input  wire logic                   i_reset,
  decode_stage_registered_if.slave    bus
);
  localparam int N_REGS = 1 << NB_REG_ADDRESS;

  typedef struct packed {
    logic                       valid;
    logic [NB_DATA-1:0]         dato_ra;
    logic [NB_DATA-1:0]         dato_rb;
    logic [NB_DATA-1:0]         inmediato;
    logic [NB_DATA-1:0]         branch_target;
    logic [NB_REG_ADDRESS-1:0]  rs;
    logic [NB_REG_ADDRESS-1:0]  rt;
    logic [NB_REG_ADDRESS-1:0]  rd;
    logic [NB_OP_FIELD-1:0]     campo_op;
    logic [5:0]                 funct;
    logic [NB_JUMP_ADDRESS-1:0] jump;
    logic [NB_DATA-1:0]         pc_plus4;
  } idex_t;

  logic [NB_DATA-1:0]        regs_q [N_REGS];
  logic [NB_DATA-1:0]        regs_d [N_REGS];
  idex_t                     idex_q, idex_d;
  logic [NB_STALL_CNT-1:0]   stall_cnt_q, stall_cnt_d;

  logic [NB_DATA-1:0]        instr;
  logic [NB_REG_ADDRESS-1:0] rs, rt, rd;
  logic [NB_IMM-1:0]         imm;
  logic [NB_DATA-1:0]        imm_ext, branch_target, dato_ra, dato_rb;
  logic                      haz;

  logic                      rw_ex, rw_mem, rw_wb;
  logic [NB_REG_ADDRESS-1:0] rd_ex, rd_mem, rd_wb;
  logic [NB_DATA-1:0]        dato_ex, dato_mem, dato_wb;

  assign rw_ex    = bus.i_reg_write_ex;
  assign rw_mem   = bus.i_reg_write_mem;
  assign rw_wb    = bus.i_reg_write_wb;
  assign rd_ex    = bus.i_rd_ex;
  assign rd_mem   = bus.i_rd_mem;
  assign rd_wb    = bus.i_rd_wb;
  assign dato_ex  = bus.i_dato_ex;
  assign dato_mem = bus.i_dato_mem;
  assign dato_wb  = bus.i_dato_wb;

  assign instr = bus.i_instruccion;
  assign rs    = instr[25 -: NB_REG_ADDRESS];
  assign rt    = instr[20 -: NB_REG_ADDRESS];
  assign rd    = instr[15 -: NB_REG_ADDRESS];
  assign imm   = instr[NB_IMM-1:0];

  // WB is the lowest-priority bypass, which also gives the file its write-through.
  function automatic logic [NB_DATA-1:0] read_operand(input logic [NB_REG_ADDRESS-1:0] addr,
                                                      input logic use_ex_mem);
    logic [NB_DATA-1:0] v;
    if (addr == '0)
      v = '0;
    else if (use_ex_mem && rw_ex && rd_ex != '0 && rd_ex == addr)
      v = dato_ex;
    else if (use_ex_mem && rw_mem && rd_mem != '0 && rd_mem == addr)
      v = dato_mem;
    else if (rw_wb && rd_wb != '0 && rd_wb == addr)
      v = dato_wb;
    else
      v = regs_q[addr];
    return v;
  endfunction

  always_comb begin
    regs_d = regs_q;
    if (rw_wb && rd_wb != '0)
      regs_d[rd_wb] = dato_wb;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < N_REGS; i++)
        regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    imm_ext = bus.i_zero_extend ? {{(NB_DATA-NB_IMM){1'b0}}, imm}
                                : {{(NB_DATA-NB_IMM){imm[NB_IMM-1]}}, imm};
    branch_target = bus.i_pc_plus4 + (imm_ext << 2);
    dato_ra = read_operand(rs, 1'b1);
    dato_rb = read_operand(rt, 1'b1);
    haz = bus.i_instr_valid && rw_ex && bus.i_mem_read_ex && rd_ex != '0 &&
          (rd_ex == rs || rd_ex == rt);
  end

  assign bus.o_stall      = bus.i_stall_ext | (haz & ~bus.i_flush);
  assign bus.o_dato_debug = read_operand(bus.i_direc_debug, 1'b0);

  always_comb begin
    idex_d      = idex_q;
    stall_cnt_d = stall_cnt_q;
    if (bus.i_flush) begin
      idex_d = '0;
    end else if (bus.i_stall_ext) begin
      idex_d = idex_q;
    end else if (haz) begin
      idex_d.valid = 1'b0;
      if (!(&stall_cnt_q))
        stall_cnt_d = stall_cnt_q + {{(NB_STALL_CNT-1){1'b0}}, 1'b1};
    end else begin
      idex_d.valid         = bus.i_instr_valid;
      idex_d.dato_ra       = dato_ra;
      idex_d.dato_rb       = dato_rb;
      idex_d.inmediato     = imm_ext;
      idex_d.branch_target = branch_target;
      idex_d.rs            = rs;
      idex_d.rt            = rt;
      idex_d.rd            = rd;
      idex_d.campo_op      = instr[31 -: NB_OP_FIELD];
      idex_d.funct         = instr[5:0];
      idex_d.jump          = instr[NB_JUMP_ADDRESS-1:0];
      idex_d.pc_plus4      = bus.i_pc_plus4;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      idex_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      idex_q      <= idex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.o_valid           = idex_q.valid;
  assign bus.o_dato_ra         = idex_q.dato_ra;
  assign bus.o_dato_rb         = idex_q.dato_rb;
  assign bus.o_inmediato       = idex_q.inmediato;
  assign bus.o_branch_target   = idex_q.branch_target;
  assign bus.o_direccion_rs    = idex_q.rs;
  assign bus.o_direccion_rt    = idex_q.rt;
  assign bus.o_direccion_rd    = idex_q.rd;
  assign bus.o_campo_op        = idex_q.campo_op;
  assign bus.o_funct           = idex_q.funct;
  assign bus.o_dato_direc_jump = idex_q.jump;
  assign bus.o_pc_plus4        = idex_q.pc_plus4;
  assign bus.o_stall_count     = stall_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_decode_stage_registered.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_decode_stage_registered : directed self-checking bench for the decode stage
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_decode_stage_registered;
  logic i_clock = 1'b0;
  logic i_reset;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  always #5 i_clock = ~i_clock;

  decode_stage_registered_if bus ();

  decode_stage_registered dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp)
      pass_cnt++;
    else
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  task automatic clear_bypass();
    bus.i_reg_write_ex  = 0; bus.i_mem_read_ex = 0; bus.i_rd_ex  = 0; bus.i_dato_ex  = 0;
    bus.i_reg_write_mem = 0; bus.i_rd_mem      = 0; bus.i_dato_mem = 0;
    bus.i_reg_write_wb  = 0; bus.i_rd_wb       = 0; bus.i_dato_wb  = 0;
  endtask

  // Advance one edge and settle before sampling registered outputs.
  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  initial begin
    i_reset           = 1;
    bus.i_instr_valid = 0;
    bus.i_instruccion = 0;
    bus.i_pc_plus4    = 0;
    bus.i_flush       = 0;
    bus.i_stall_ext   = 0;
    bus.i_zero_extend = 0;
    bus.i_direc_debug = 0;
    clear_bypass();
    step();
    step();
    check("rst_valid", {31'd0, bus.o_valid}, 32'h0);
    check("rst_ra", bus.o_dato_ra, 32'h0);
    check("rst_imm", bus.o_inmediato, 32'h0);
    check("rst_cnt", {16'd0, bus.o_stall_count}, 32'h0);
    i_reset = 0;

    // WB write r5, then read it back through the file
    bus.i_reg_write_wb = 1; bus.i_rd_wb = 5; bus.i_dato_wb = 32'h1234;
    step();
    clear_bypass();
    bus.i_direc_debug = 5;
    #1 check("dbg_r5", bus.o_dato_debug, 32'h1234);
    bus.i_direc_debug = 0;
    #1 check("dbg_r0", bus.o_dato_debug, 32'h0);
    bus.i_instr_valid = 1;
    bus.i_instruccion = r_type(5'd5, 5'd0, 5'd1, 6'h20);
    bus.i_pc_plus4    = 32'h40;
    step();
    check("rd_r5_ra", bus.o_dato_ra, 32'h1234);
    check("rd_r5_rb", bus.o_dato_rb, 32'h0);
    check("rd_r5_valid", {31'd0, bus.o_valid}, 32'h1);
    check("rd_r5_rs", {27'd0, bus.o_direccion_rs}, 32'd5);
    check("rd_r5_rd", {27'd0, bus.o_direccion_rd}, 32'd1);
    check("rd_r5_funct", {26'd0, bus.o_funct}, 32'h20);
    check("rd_r5_pc", bus.o_pc_plus4, 32'h40);

    // forwarding priority EX > MEM > WB > file
    bus.i_reg_write_wb  = 1; bus.i_rd_wb  = 3; bus.i_dato_wb  = 32'hAA;
    bus.i_reg_write_mem = 1; bus.i_rd_mem = 3; bus.i_dato_mem = 32'hBB;
    bus.i_reg_write_ex  = 1; bus.i_rd_ex  = 3; bus.i_dato_ex  = 32'hCC;
    bus.i_instruccion = r_type(5'd3, 5'd3, 5'd4, 6'h21);
    step();
    check("fwd_ex_ra", bus.o_dato_ra, 32'hCC);
    check("fwd_ex_rb", bus.o_dato_rb, 32'hCC);
    bus.i_rd_ex = 0;
    step();
    check("fwd_mem_ra", bus.o_dato_ra, 32'hBB);
    check("fwd_mem_rb", bus.o_dato_rb, 32'hBB);
    clear_bypass();
    step();
    check("file_r3", bus.o_dato_ra, 32'hAA);

    // load-use hazard on rt
    bus.i_reg_write_ex = 1; bus.i_mem_read_ex = 1; bus.i_rd_ex = 7; bus.i_dato_ex = 32'hDEAD;
    bus.i_instruccion = r_type(5'd1, 5'd7, 5'd8, 6'h20);
    #1 check("lu_stall", {31'd0, bus.o_stall}, 32'h1);
    step();
    check("lu_bubble", {31'd0, bus.o_valid}, 32'h0);
    check("lu_cnt", {16'd0, bus.o_stall_count}, 32'd1);
    clear_bypass();
    bus.i_reg_write_mem = 1; bus.i_rd_mem = 7; bus.i_dato_mem = 32'h777;
    #1 check("lu_release", {31'd0, bus.o_stall}, 32'h0);
    step();
    check("lu_issue_valid", {31'd0, bus.o_valid}, 32'h1);
    check("lu_issue_rb", bus.o_dato_rb, 32'h777);
    check("lu_issue_ra", bus.o_dato_ra, 32'h0);
    check("lu_issue_cnt", {16'd0, bus.o_stall_count}, 32'd1);

    // hazard squashed by flush
    clear_bypass();
    bus.i_reg_write_ex = 1; bus.i_mem_read_ex = 1; bus.i_rd_ex = 7;
    bus.i_flush = 1;
    #1 check("fl_stall", {31'd0, bus.o_stall}, 32'h0);
    step();
    check("fl_valid", {31'd0, bus.o_valid}, 32'h0);
    check("fl_cnt", {16'd0, bus.o_stall_count}, 32'd1);
    bus.i_flush = 0;
    clear_bypass();

    // immediate extension and branch target
    bus.i_instruccion = i_type(6'h08, 5'd0, 5'd2, 16'hFFFC);
    bus.i_pc_plus4    = 32'h100;
    step();
    check("sx_imm", bus.o_inmediato, 32'hFFFF_FFFC);
    check("sx_tgt", bus.o_branch_target, 32'h0000_00F0);
    check("sx_op", {26'd0, bus.o_campo_op}, 32'h08);
    check("sx_rt", {27'd0, bus.o_direccion_rt}, 32'd2);
    check("sx_jump", {6'd0, bus.o_dato_direc_jump}, 32'h0002_FFFC);
    bus.i_zero_extend = 1;
    step();
    check("zx_imm", bus.o_inmediato, 32'h0000_FFFC);
    check("zx_tgt", bus.o_branch_target, 32'h0004_00F0);

    // external stall freezes the ID/EX register
    bus.i_stall_ext   = 1;
    bus.i_zero_extend = 0;
    bus.i_instruccion = i_type(6'h23, 5'd9, 5'd10, 16'h0001);
    bus.i_pc_plus4    = 32'h200;
    for (int i = 0; i < 3; i++) begin
      #1 check("se_stall", {31'd0, bus.o_stall}, 32'h1);
      step();
      check("se_imm", bus.o_inmediato, 32'h0000_FFFC);
      check("se_pc", bus.o_pc_plus4, 32'h100);
      check("se_valid", {31'd0, bus.o_valid}, 32'h1);
    end
    i_reset = 1;
    step();
    check("sr_valid", {31'd0, bus.o_valid}, 32'h0);
    check("sr_imm", bus.o_inmediato, 32'h0);
    check("sr_pc", bus.o_pc_plus4, 32'h0);
    check("sr_cnt", {16'd0, bus.o_stall_count}, 32'h0);
    i_reset = 0;
    bus.i_direc_debug = 5;
    #1 check("sr_file", bus.o_dato_debug, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
`default_nettype wire
